axil_byte_regbank: RTL and testbench

- Byte-wide AXI-lite-style slave register bank inside the chip core, directly downstream of the pad/io connection stage.
- Consumes the pad-side address/write/read handshakes (AWRITEB, AADDR, AVALID, WDATA, WVALID, RREADY).
- Produces the control-register image that drives heaters, odometers, temperature sensors and the lockstep cores.
- Returns read data, including read-only status bytes from those blocks.

---
 rtl/axil_byte_regbank.sv | 118 +++++++++++
 tb/tb_axil_byte_regbank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_byte_regbank.sv
// Byte-wide AXI-lite-style register bank: RW control registers plus read-only status bytes.
// Latency: read data and RVALID one cycle after address accept; write lands on the data-accept edge.
// Backpressure: one transaction in flight; a held RVALID blocks new addresses until RREADY.
module axil_byte_regbank #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_RW_REGS = 48,
    localparam int NUM_RO_REGS = (2**ADDR_WIDTH) - NUM_RW_REGS
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              AWRITEB,
    input  logic [ADDR_WIDTH-1:0]             AADDR,
    input  logic                              AVALID,
    output logic                              AREADY,
    input  logic [DATA_WIDTH-1:0]             WDATA,
    input  logic                              WVALID,
    output logic                              WREADY,
    output logic [DATA_WIDTH-1:0]             RDATA,
    output logic                              RVALID,
    input  logic                              RREADY,
    output logic [NUM_RW_REGS*DATA_WIDTH-1:0] REG_OUT,
    output logic [NUM_RW_REGS-1:0]            WR_PULSE,
    input  logic [NUM_RO_REGS*DATA_WIDTH-1:0] STATUS_IN,
    output logic [NUM_RO_REGS-1:0]            RD_PULSE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WDAT = 2'd1,
        RRSP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_RW_REGS-1:0]  wr_pulse_q, wr_pulse_d;
    logic [NUM_RO_REGS-1:0]  rd_pulse_q, rd_pulse_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_RW_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_RW_REGS];

    // Reset must mask AREADY combinationally so no address is taken on a reset edge.
    assign AREADY   = (state_q == IDLE) && !ARESET;
    assign WREADY   = (state_q == WDAT);
    assign RVALID   = (state_q == RRSP);
    assign RDATA    = rdata_q;
    assign WR_PULSE = wr_pulse_q;
    assign RD_PULSE = rd_pulse_q;

    for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_reg_out
        assign REG_OUT[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        wr_pulse_d = '0;
        rd_pulse_d = '0;
        regs_d     = regs_q;
        case (state_q)
            IDLE: begin
                if (AVALID) begin
                    addr_d = AADDR;
                    if (AWRITEB) begin
                        state_d = RRSP;
                        for (int k = 0; k < NUM_RW_REGS; k++) begin
                            if (AADDR == ADDR_WIDTH'(k)) rdata_d = regs_q[k];
                        end
                        for (int j = 0; j < NUM_RO_REGS; j++) begin
                            if (AADDR == ADDR_WIDTH'(NUM_RW_REGS + j)) begin
                                rdata_d       = STATUS_IN[j*DATA_WIDTH +: DATA_WIDTH];
                                rd_pulse_d[j] = 1'b1;
                            end
                        end
                    end else begin
                        state_d = WDAT;
                    end
                end
            end
            WDAT: begin
                if (WVALID) begin
                    state_d = IDLE;
                    // Writes to the status window fall through every compare and are dropped.
                    for (int k = 0; k < NUM_RW_REGS; k++) begin
                        if (addr_q == ADDR_WIDTH'(k)) begin
                            regs_d[k]     = WDATA;
                            wr_pulse_d[k] = 1'b1;
                        end
                    end
                end
            end
            RRSP: begin
                if (RREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
            for (int k = 0; k < NUM_RW_REGS; k++) regs_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            for (int k = 0; k < NUM_RW_REGS; k++) regs_q[k] <= regs_d[k];
        end
    end

endmodule

// File: tb/tb_axil_byte_regbank.sv
// Directed, table-driven bench for axil_byte_regbank with a small register-image model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_axil_byte_regbank;

    localparam int AW  = 6;
    localparam int DW  = 8;
    localparam int NRW = 48;
    localparam int NRO = 16;
    localparam int CW  = NRW * DW;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              AWRITEB;
    logic [AW-1:0]     AADDR;
    logic              AVALID;
    logic              AREADY;
    logic [DW-1:0]     WDATA;
    logic              WVALID;
    logic              WREADY;
    logic [DW-1:0]     RDATA;
    logic              RVALID;
    logic              RREADY;
    logic [CW-1:0]     REG_OUT;
    logic [NRW-1:0]    WR_PULSE;
    logic [NRO*DW-1:0] STATUS_IN;
    logic [NRO-1:0]    RD_PULSE;

    always #5 ACLK = ~ACLK;

    axil_byte_regbank dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .AWRITEB   (AWRITEB),
        .AADDR     (AADDR),
        .AVALID    (AVALID),
        .AREADY    (AREADY),
        .WDATA     (WDATA),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .RDATA     (RDATA),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .REG_OUT   (REG_OUT),
        .WR_PULSE  (WR_PULSE),
        .STATUS_IN (STATUS_IN),
        .RD_PULSE  (RD_PULSE)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] model [NRW];

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        int            stall;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] exp_regs();
        logic [CW-1:0] e;
        e = '0;
        for (int k = 0; k < NRW; k++) e[k*DW +: DW] = model[k];
        return e;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NRW; k++) model[k] = '0;
    endtask

    task automatic cyc();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic wait_aready();
        int n;
        n = 0;
        while (!AREADY && n < 20) begin
            cyc();
            n++;
        end
        chk("aready_timeout", CW'(n < 20), CW'(1));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [NRW-1:0] ep;
        ep = '0;
        AWRITEB = 1'b0;
        AADDR   = a;
        AVALID  = 1'b1;
        wait_aready();
        cyc();
        AVALID = 1'b0;
        chk("wready_after_aw", CW'(WREADY), CW'(1));
        chk("aready_in_wdat", CW'(AREADY), CW'(0));
        WDATA  = d;
        WVALID = 1'b1;
        cyc();
        WVALID = 1'b0;
        if (int'(a) < NRW) begin
            model[a] = d;
            ep[a]    = 1'b1;
        end
        chk("wr_pulse", CW'(WR_PULSE), CW'(ep));
        chk("reg_out_after_wr", REG_OUT, exp_regs());
        chk("wready_drop", CW'(WREADY), CW'(0));
        cyc();
        chk("wr_pulse_clear", CW'(WR_PULSE), CW'(0));
    endtask

    // Status inputs are inverted while the response is held to prove RDATA is a snapshot.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] er, input int stall);
        logic [NRO-1:0] ep;
        ep = '0;
        if (int'(a) >= NRW) ep[4'(a - 6'(NRW))] = 1'b1;
        AWRITEB = 1'b1;
        AADDR   = a;
        AVALID  = 1'b1;
        wait_aready();
        cyc();
        AVALID = 1'b0;
        chk("rvalid", CW'(RVALID), CW'(1));
        chk("rdata", CW'(RDATA), CW'(er));
        chk("rd_pulse", CW'(RD_PULSE), CW'(ep));
        STATUS_IN = ~STATUS_IN;
        for (int i = 0; i < stall; i++) begin
            cyc();
            chk("rdata_hold", CW'(RDATA), CW'(er));
            chk("rvalid_hold", CW'(RVALID), CW'(1));
            chk("rd_pulse_clear", CW'(RD_PULSE), CW'(0));
        end
        RREADY = 1'b1;
        cyc();
        RREADY    = 1'b0;
        STATUS_IN = ~STATUS_IN;
        chk("rvalid_drop", CW'(RVALID), CW'(0));
        chk("rd_pulse_after", CW'(RD_PULSE), CW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 6'd5,  8'hA3, 0};
        vecs[1]  = '{1'b0, 6'd5,  8'hA3, 4};
        vecs[2]  = '{1'b0, 6'd50, 8'h5C, 3};
        vecs[3]  = '{1'b1, 6'd60, 8'hFF, 0};
        vecs[4]  = '{1'b0, 6'd60, 8'hCC, 0};
        vecs[5]  = '{1'b1, 6'd0,  8'h11, 0};
        vecs[6]  = '{1'b1, 6'd47, 8'h5A, 0};
        vecs[7]  = '{1'b0, 6'd0,  8'h11, 0};
        vecs[8]  = '{1'b0, 6'd47, 8'h5A, 1};
        vecs[9]  = '{1'b0, 6'd48, 8'hC0, 0};
        vecs[10] = '{1'b0, 6'd63, 8'hCF, 2};
        vecs[11] = '{1'b1, 6'd5,  8'h3C, 0};
        vecs[12] = '{1'b0, 6'd5,  8'h3C, 1};

        for (int j = 0; j < NRO; j++) STATUS_IN[j*DW +: DW] = 8'hC0 + 8'(j);
        STATUS_IN[2*DW +: DW] = 8'h5C;
        clear_model();
        ARESET  = 1'b1;
        AWRITEB = 1'b0;
        AADDR   = '0;
        AVALID  = 1'b0;
        WDATA   = '0;
        WVALID  = 1'b0;
        RREADY  = 1'b0;

        @(negedge ACLK);
        chk("aready_in_reset_0", CW'(AREADY), CW'(0));
        cyc();
        chk("aready_in_reset_1", CW'(AREADY), CW'(0));
        ARESET = 1'b0;
        #1;
        chk("aready_after_reset", CW'(AREADY), CW'(1));
        chk("reg_out_reset", REG_OUT, CW'(0));
        chk("rvalid_reset", CW'(RVALID), CW'(0));
        chk("wready_reset", CW'(WREADY), CW'(0));
        chk("rdata_reset", CW'(RDATA), CW'(0));
        @(negedge ACLK);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].dat);
            else            do_read(vecs[v].addr, vecs[v].dat, vecs[v].stall);
        end

        // Reset between address and data phases of a write.
        AWRITEB = 1'b0;
        AADDR   = 6'd7;
        AVALID  = 1'b1;
        wait_aready();
        cyc();
        AVALID = 1'b0;
        chk("mid_wr_wready", CW'(WREADY), CW'(1));
        ARESET = 1'b1;
        WDATA  = 8'h77;
        cyc();
        ARESET = 1'b0;
        clear_model();
        #1;
        chk("mid_wr_wready_drop", CW'(WREADY), CW'(0));
        chk("mid_wr_aready", CW'(AREADY), CW'(1));
        chk("mid_wr_regs_cleared", REG_OUT, exp_regs());
        @(negedge ACLK);
        WVALID = 1'b1;
        cyc();
        chk("idle_wvalid_no_pulse", CW'(WR_PULSE), CW'(0));
        cyc();
        WVALID = 1'b0;
        chk("idle_wvalid_no_write", REG_OUT, exp_regs());
        chk("idle_wvalid_wready", CW'(WREADY), CW'(0));

        // Reset while a read response is being held.
        do_write(6'd9, 8'h44);
        AWRITEB = 1'b1;
        AADDR   = 6'd9;
        AVALID  = 1'b1;
        wait_aready();
        cyc();
        AVALID = 1'b0;
        chk("mid_rd_rdata", CW'(RDATA), CW'(8'h44));
        ARESET = 1'b1;
        cyc();
        ARESET = 1'b0;
        clear_model();
        #1;
        chk("mid_rd_rvalid_drop", CW'(RVALID), CW'(0));
        chk("mid_rd_rdata_cleared", CW'(RDATA), CW'(0));
        chk("mid_rd_regs_cleared", REG_OUT, exp_regs());
        @(negedge ACLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
